pdp8l_iop_seq: RTL and testbench



---
 rtl/pdp8l_iop_pkg.sv | 31 +++
 rtl/pdp8l_edgedet.sv | 46 ++++
 rtl/pdp8l_iop_seq.sv | 185 ++++++++++++++++++
 tb/tb_pdp8l_iop_seq.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pdp8l_iop_pkg.sv
// Shared definitions for the PDP-8/L IOT sequencer: state encoding,
// ARM register map, identification word and reset defaults.
package pdp8l_iop_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_WAITEND = 2'd2
  } iop_state_e;

  // 'IS' in the top half, size code 1 (four registers), version in the low bits
  localparam logic [31:0] IDENT_BASE = 32'h4953_1000;

  localparam logic [1:0] REG_IDENT  = 2'd0;
  localparam logic [1:0] REG_CTRL   = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_LASTAC = 2'd3;

  localparam logic [15:0] TMO_DEFAULT = 16'd1000;
  localparam logic [11:0] VERSION     = 12'h001;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      return v;
    end else begin
      return v + 16'd1;
    end
  endfunction

endpackage

// File: rtl/pdp8l_edgedet.sv
// Three-lane rising-edge detector advanced only on CSTEP cycles. The level
// history always tracks the inputs; the registered strobes are only allowed
// through while gate_i is high and are forced low otherwise.
module pdp8l_edgedet (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cstep_i,
  input  logic       gate_i,
  input  logic [2:0] lvl_i,
  output logic [2:0] strobe_o
);

  logic [2:0] prev_q, prev_d;
  logic [2:0] strobe_q, strobe_d;

  // Next history and strobe values; everything holds when CSTEP is low
  always_comb begin
    prev_d   = prev_q;
    strobe_d = strobe_q;
    if (cstep_i) begin
      prev_d = lvl_i;
      if (gate_i) begin
        strobe_d = lvl_i & ~prev_q;
      end else begin
        strobe_d = 3'b000;
      end
    end else begin
      prev_d   = prev_q;
      strobe_d = strobe_q;
    end
  end

  // History and strobe registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_q   <= 3'b000;
      strobe_q <= 3'b000;
    end else begin
      prev_q   <= prev_d;
      strobe_q <= strobe_d;
    end
  end

  assign strobe_o = strobe_q;

endmodule

// File: rtl/pdp8l_iop_seq.sv
// IOT sequencer: frames each IOT with iopstart/iopstop, latches the
// instruction and AC words, produces per-IOP strobes and guards against
// an IOT that never ends with a CSTEP-cycle timeout. ARM-visible control
// and status registers sit alongside.
module pdp8l_iop_seq #(
  parameter logic [15:0] TMO_DEFAULT = pdp8l_iop_pkg::TMO_DEFAULT,
  parameter logic [11:0] VERSION     = pdp8l_iop_pkg::VERSION
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        CSTEP,
  input  logic        armwrite,
  input  logic [1:0]  armraddr,
  input  logic [1:0]  armwaddr,
  input  logic [31:0] armwdata,
  output logic [31:0] armrdata,
  input  logic        ioinst,
  input  logic        iop1,
  input  logic        iop2,
  input  logic        iop4,
  input  logic [11:0] mbus,
  input  logic [11:0] acbus,
  output logic        iopstart,
  output logic        iopstop,
  output logic [11:0] ioopcode,
  output logic [11:0] cputodev,
  output logic [2:0]  iopstrobe
);

  import pdp8l_iop_pkg::*;

  iop_state_e  state_q, state_d;
  logic        enable_q, enable_d;
  logic [15:0] timeout_q, timeout_d;
  logic [15:0] iocount_q, iocount_d;
  logic        timedout_q, timedout_d;
  logic [15:0] tcnt_q, tcnt_d;
  logic [11:0] ioopcode_q, ioopcode_d;
  logic [11:0] cputodev_q, cputodev_d;
  logic        iopstart_q, iopstart_d;
  logic        iopstop_q, iopstop_d;
  logic        strobe_gate_s;
  logic        unused_wdata_s;

  // Control-register bits that have no storage behind them
  assign unused_wdata_s = ^armwdata[30:16];

  // Strobes are only meaningful while an IOT is live and has not just ended
  assign strobe_gate_s = (state_q == ST_ACTIVE) && ioinst;

  pdp8l_edgedet u_edgedet (
    .clk_i    (CLOCK),
    .rst_i    (RESET),
    .cstep_i  (CSTEP),
    .gate_i   (strobe_gate_s),
    .lvl_i    ({iop4, iop2, iop1}),
    .strobe_o (iopstrobe)
  );

  // Next-state and next-output logic; ARM writes are applied last so a
  // status clear overrides a same-cycle count increment or timeout flag
  always_comb begin
    state_d    = state_q;
    enable_d   = enable_q;
    timeout_d  = timeout_q;
    iocount_d  = iocount_q;
    timedout_d = timedout_q;
    tcnt_d     = tcnt_q;
    ioopcode_d = ioopcode_q;
    cputodev_d = cputodev_q;
    iopstart_d = iopstart_q;
    iopstop_d  = iopstop_q;

    if (CSTEP) begin
      case (state_q)
        ST_IDLE: begin
          if (enable_q && ioinst) begin
            ioopcode_d = mbus;
            cputodev_d = acbus;
            iopstart_d = 1'b1;
            iopstop_d  = 1'b0;
            iocount_d  = iocount_q + 16'd1;
            tcnt_d     = 16'd0;
            state_d    = ST_ACTIVE;
          end else begin
            iopstart_d = 1'b0;
            iopstop_d  = 1'b0;
          end
        end
        ST_ACTIVE: begin
          iopstart_d = 1'b0;
          tcnt_d     = sat_inc16(tcnt_q);
          if (!ioinst) begin
            iopstop_d = 1'b1;
            state_d   = ST_IDLE;
          end else if ((timeout_q != 16'd0) && (tcnt_q == (timeout_q - 16'd1))) begin
            iopstop_d  = 1'b1;
            timedout_d = 1'b1;
            state_d    = ST_WAITEND;
          end else begin
            state_d = ST_ACTIVE;
          end
        end
        ST_WAITEND: begin
          iopstop_d = 1'b0;
          if (!ioinst) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WAITEND;
          end
        end
        default: begin
          state_d    = ST_IDLE;
          iopstart_d = 1'b0;
          iopstop_d  = 1'b0;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    if (armwrite) begin
      case (armwaddr)
        REG_CTRL: begin
          enable_d  = armwdata[31];
          timeout_d = armwdata[15:0];
        end
        REG_STATUS: begin
          timedout_d = 1'b0;
          iocount_d  = 16'd0;
        end
        default: begin
          enable_d = enable_d;
        end
      endcase
    end else begin
      enable_d = enable_d;
    end
  end

  // State and register file with synchronous reset
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      enable_q   <= 1'b1;
      timeout_q  <= TMO_DEFAULT;
      iocount_q  <= 16'd0;
      timedout_q <= 1'b0;
      tcnt_q     <= 16'd0;
      ioopcode_q <= 12'd0;
      cputodev_q <= 12'd0;
      iopstart_q <= 1'b0;
      iopstop_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      enable_q   <= enable_d;
      timeout_q  <= timeout_d;
      iocount_q  <= iocount_d;
      timedout_q <= timedout_d;
      tcnt_q     <= tcnt_d;
      ioopcode_q <= ioopcode_d;
      cputodev_q <= cputodev_d;
      iopstart_q <= iopstart_d;
      iopstop_q  <= iopstop_d;
    end
  end

  // ARM read mux, combinational on the read index
  always_comb begin
    armrdata = 32'd0;
    case (armraddr)
      REG_IDENT:  armrdata = IDENT_BASE | {20'd0, VERSION};
      REG_CTRL:   armrdata = {enable_q, 15'd0, timeout_q};
      REG_STATUS: armrdata = {timedout_q, state_q, 1'b0, ioopcode_q, iocount_q};
      REG_LASTAC: armrdata = {20'd0, cputodev_q};
      default:    armrdata = 32'd0;
    endcase
  end

  assign iopstart = iopstart_q;
  assign iopstop  = iopstop_q;
  assign ioopcode = ioopcode_q;
  assign cputodev = cputodev_q;

endmodule

// File: tb/tb_pdp8l_iop_seq.sv
// Self-checking bench for pdp8l_iop_seq: directed scenarios followed by a
// randomized run, all checked every clock against a behavioural model.
module tb_pdp8l_iop_seq;

  logic        CLOCK = 1'b0;
  logic        RESET, CSTEP, armwrite, ioinst, iop1, iop2, iop4;
  logic [1:0]  armraddr, armwaddr;
  logic [31:0] armwdata, armrdata;
  logic [11:0] mbus, acbus, ioopcode, cputodev;
  logic        iopstart, iopstop;
  logic [2:0]  iopstrobe;

  int n_vec = 0;
  int n_err = 0;

  pdp8l_iop_seq dut (
    .CLOCK(CLOCK), .RESET(RESET), .CSTEP(CSTEP),
    .armwrite(armwrite), .armraddr(armraddr), .armwaddr(armwaddr),
    .armwdata(armwdata), .armrdata(armrdata),
    .ioinst(ioinst), .iop1(iop1), .iop2(iop2), .iop4(iop4),
    .mbus(mbus), .acbus(acbus),
    .iopstart(iopstart), .iopstop(iopstop),
    .ioopcode(ioopcode), .cputodev(cputodev), .iopstrobe(iopstrobe)
  );

  always #5 CLOCK = ~CLOCK;

  // Behavioural model: "in an IOT", "hung after timeout", plus latched data
  logic        m_busy, m_hung, m_en, m_tf, m_start, m_stop;
  logic [15:0] m_tmo, m_cnt, m_t;
  logic [11:0] m_op, m_ac;
  logic [2:0]  m_prev, m_stb;

  function automatic logic [31:0] m_read(input logic [1:0] a);
    logic [1:0] st;
    st = m_busy ? 2'd1 : (m_hung ? 2'd2 : 2'd0);
    case (a)
      2'd0:    return 32'h4953_1001;
      2'd1:    return {m_en, 15'd0, m_tmo};
      2'd2:    return {m_tf, st, 1'b0, m_op, m_cnt};
      default: return {20'd0, m_ac};
    endcase
  endfunction

  task automatic model_edge();
    logic [2:0] lv, rise;
    if (RESET) begin
      m_busy = 0; m_hung = 0; m_en = 1; m_tf = 0; m_start = 0; m_stop = 0;
      m_tmo = 16'd1000; m_cnt = 0; m_t = 0; m_op = 0; m_ac = 0;
      m_prev = 0; m_stb = 0;
      return;
    end
    if (CSTEP) begin
      lv = {iop4, iop2, iop1};
      rise = lv & ~m_prev;
      m_prev = lv;
      m_start = 0; m_stop = 0; m_stb = 0;
      if (m_busy) begin
        if (!ioinst) begin
          m_stop = 1; m_busy = 0;
        end else begin
          m_stb = rise;
          if (m_tmo != 0 && m_t == m_tmo - 16'd1) begin
            m_stop = 1; m_tf = 1; m_busy = 0; m_hung = 1;
          end
          if (m_t != 16'hFFFF) m_t = m_t + 16'd1;
        end
      end else if (m_hung) begin
        if (!ioinst) m_hung = 0;
      end else if (m_en && ioinst) begin
        m_busy = 1; m_op = mbus; m_ac = acbus; m_start = 1;
        m_cnt = m_cnt + 16'd1; m_t = 0;
      end
    end
    if (armwrite) begin
      if (armwaddr == 2'd1) begin
        m_en = armwdata[31]; m_tmo = armwdata[15:0];
      end else if (armwaddr == 2'd2) begin
        m_tf = 0; m_cnt = 0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("iopstart", {31'd0, iopstart}, {31'd0, m_start});
    chk("iopstop", {31'd0, iopstop}, {31'd0, m_stop});
    chk("ioopcode", {20'd0, ioopcode}, {20'd0, m_op});
    chk("cputodev", {20'd0, cputodev}, {20'd0, m_ac});
    chk("iopstrobe", {29'd0, iopstrobe}, {29'd0, m_stb});
    chk("armrdata", armrdata, m_read(armraddr));
  endtask

  task automatic tick();
    @(posedge CLOCK);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic arm_wr(input logic [1:0] a, input logic [31:0] d);
    armwrite = 1; armwaddr = a; armwdata = d;
    tick();
    armwrite = 0;
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] mask,
                        input logic [31:0] exp);
    armraddr = a;
    #1;
    chk(tag, armrdata & mask, exp);
  endtask

  initial begin
    int n_st, n_sp, stop_k, div;
    logic [2:0] sq[$];
    int run;

    RESET = 1; CSTEP = 1; armwrite = 0; armraddr = 0; armwaddr = 0; armwdata = 0;
    ioinst = 0; iop1 = 0; iop2 = 0; iop4 = 0; mbus = 0; acbus = 0;
    #2;
    tick(); tick();
    RESET = 0;
    tick();
    rd_chk("ident", 2'd0, 32'hFFFF_FFFF, 32'h4953_1001);
    rd_chk("ctrl_rst", 2'd1, 32'hFFFF_FFFF, 32'h8000_03E8);
    rd_chk("status_rst", 2'd2, 32'hFFFF_FFFF, 32'h0);

    // Basic IOT, first with CSTEP every clock, then CSTEP 1-of-3
    for (int pass = 0; pass < 2; pass++) begin
      div = (pass == 0) ? 1 : 3;
      n_st = 0; n_sp = 0; stop_k = -1; sq.delete();
      armraddr = 2'd2;
      for (int k = 0; k < 12; k++) begin
        for (int j = 0; j < div; j++) begin
          CSTEP = (j == 0); ioinst = (k < 10);
          iop1 = (k == 3 || k == 4); iop2 = 0; iop4 = (k == 6 || k == 7);
          mbus = 12'o6004; acbus = 12'o7777;
          tick();
          if (iopstart) n_st++;
          if (iopstop) begin
            n_sp++;
            if (stop_k < 0) stop_k = k;
          end
          if (j == 0 && iopstrobe != 3'b000) sq.push_back(iopstrobe);
        end
      end
      chk("start_clks", n_st, div);
      chk("stop_clks", n_sp, div);
      chk("stop_pos", stop_k, 10);
      chk("strobe_n", sq.size(), 2);
      if (sq.size() == 2) begin
        chk("strobe0", {29'd0, sq[0]}, 32'd1);
        chk("strobe1", {29'd0, sq[1]}, 32'd4);
      end
      chk("opcode6004", {20'd0, ioopcode}, {20'd0, 12'o6004});
      chk("ac7777", {20'd0, cputodev}, {20'd0, 12'o7777});
      rd_chk("iocount", 2'd2, 32'h0000_FFFF, pass + 1);
    end

    // Hang timeout of 5 CSTEP cycles
    CSTEP = 0;
    arm_wr(2'd1, 32'h8000_0005);
    CSTEP = 1; n_st = 0; stop_k = -1;
    for (int k = 0; k < 20; k++) begin
      ioinst = 1; iop1 = $urandom_range(0, 1); mbus = 12'($urandom); acbus = 12'($urandom);
      tick();
      if (iopstart) n_st++;
      if (iopstop && stop_k < 0) stop_k = k;
    end
    chk("tmo_starts", n_st, 1);
    chk("tmo_stop_pos", stop_k, 5);
    rd_chk("tmo_status", 2'd2, 32'hE000_0000, 32'hC000_0000);
    ioinst = 0;
    tick();
    arm_wr(2'd2, 32'h0);
    rd_chk("status_clr", 2'd2, 32'h8000_FFFF, 32'h0);

    // Enable cleared: no starts, count unchanged
    arm_wr(2'd1, 32'h0000_03E8);
    n_st = 0;
    for (int k = 0; k < 5; k++) begin
      ioinst = (k < 3);
      tick();
      if (iopstart) n_st++;
    end
    chk("dis_starts", n_st, 0);
    rd_chk("dis_count", 2'd2, 32'h0000_FFFF, 32'h0);

    // Enable dropped mid-IOT still ends normally
    arm_wr(2'd1, 32'h8000_03E8);
    ioinst = 1; mbus = 12'o6031; acbus = 12'o1234;
    tick(); tick();
    arm_wr(2'd1, 32'h0000_03E8);
    ioinst = 0;
    tick();
    chk("dis_mid_stop", {31'd0, iopstop}, 32'd1);

    // Reset while an IOT is in progress
    arm_wr(2'd1, 32'h8000_03E8);
    ioinst = 1; mbus = 12'o6046; acbus = 12'o0525;
    tick(); tick();
    RESET = 1;
    tick();
    chk("rst_outs", {iopstart, iopstop, ioopcode, cputodev, iopstrobe}, 32'd0);
    RESET = 0; ioinst = 0;
    tick();
    chk("rst_nostop", {31'd0, iopstop}, 32'd0);

    // Count wrap from all-ones
    CSTEP = 0;
    force dut.iocount_q = 16'hFFFF;
    #1;
    release dut.iocount_q;
    m_cnt = 16'hFFFF;
    CSTEP = 1; ioinst = 1;
    tick();
    rd_chk("wrap", 2'd2, 32'h0000_FFFF, 32'h0);
    ioinst = 0;
    tick();

    // Randomized traffic
    run = 0;
    for (int k = 0; k < 800; k++) begin
      CSTEP = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 5) == 0) ioinst = ~ioinst;
      if ($urandom_range(0, 3) == 0) iop1 = ~iop1;
      if ($urandom_range(0, 3) == 0) iop2 = ~iop2;
      if ($urandom_range(0, 3) == 0) iop4 = ~iop4;
      mbus = 12'($urandom); acbus = 12'($urandom);
      armraddr = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) begin
        armwrite = 1; armwaddr = 2'($urandom_range(0, 3));
        armwdata = {($urandom_range(0, 7) != 0), 15'($urandom), 16'($urandom_range(0, 8))};
      end else begin
        armwrite = 0;
      end
      tick();
      if (iopstart) run++;
    end
    armwrite = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
